// File: rtl/vga_timing_gen_if.sv
// rtl/vga_timing_gen_if.sv - signal bundle between the VGA timing generator and its consumers
interface vga_timing_gen_if;
  logic       vgaCLK;
  logic       pixel_tick;
  logic       hsync;
  logic       vsync;
  logic       video_on;
  logic [9:0] pixel_x;
  logic [9:0] pixel_y;
  logic       frame_start;

  // master: the timing generator (samples vgaCLK, drives timing)
  modport master (
    input  vgaCLK,
    output pixel_tick, hsync, vsync, video_on, pixel_x, pixel_y, frame_start
  );

  // slave: the divider/renderer side
  modport slave (
    output vgaCLK,
    input  pixel_tick, hsync, vsync, video_on, pixel_x, pixel_y, frame_start
  );
endinterface

// File: rtl/vga_timing_gen.sv
// rtl/vga_timing_gen.sv - 640x480@60 VGA timing on boardCLK; VGA_EDGE_DETECT_EN selects the vgaCLK edge-detect tick source
module vga_timing_gen #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter bit SYNC_POL = 1'b0
) (
  input  logic             boardCLK,
  input  logic             reset,
  vga_timing_gen_if.master vga
);

  localparam logic [9:0] H_LAST   = 10'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
  localparam logic [9:0] V_LAST   = 10'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
  localparam logic [9:0] H_VIS    = 10'(H_ACTIVE);
  localparam logic [9:0] V_VIS    = 10'(V_ACTIVE);
  localparam logic [9:0] HS_START = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS_END   = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [9:0] VS_START = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS_END   = 10'(V_ACTIVE + V_FP + V_SYNC - 1);

  logic       tick;
  logic [9:0] hCnt;
  logic [9:0] vCnt;
  logic [9:0] hNext;
  logic [9:0] vNext;
  logic       hsyncReg;
  logic       vsyncReg;
  logic       lineEnd;
  logic       frameEnd;

`ifdef VGA_EDGE_DETECT_EN
  logic vgaSync1;
  logic vgaSync2;
  logic vgaPrev;

  // two-flop synchroniser on the divider output plus a previous-value flop for rise detection
  always_ff @(posedge boardCLK or posedge reset) begin
    if (reset) begin
      vgaSync1 <= 1'b0;
      vgaSync2 <= 1'b0;
      vgaPrev  <= 1'b0;
    end else begin
      vgaSync1 <= vga.vgaCLK;
      vgaSync2 <= vgaSync1;
      vgaPrev  <= vgaSync2;
    end
  end

  assign tick = vgaSync2 & ~vgaPrev;
`else
  logic [1:0] prescale;

  // free-running divide-by-4; phase is anchored to reset release, vgaCLK is not used
  always_ff @(posedge boardCLK or posedge reset) begin
    if (reset) begin
      prescale <= 2'd0;
    end else begin
      prescale <= prescale + 2'd1;
    end
  end

  assign tick = (prescale == 2'd3);
`endif

  assign lineEnd  = (hCnt == H_LAST);
  assign frameEnd = lineEnd && (vCnt == V_LAST);

  // next-count values: counters only move on a pixel tick, vertical only at end of line
  always_comb begin
    hNext = hCnt;
    vNext = vCnt;
    if (tick) begin
      hNext = lineEnd ? 10'd0 : hCnt + 10'd1;
      if (lineEnd) begin
        vNext = (vCnt == V_LAST) ? 10'd0 : vCnt + 10'd1;
      end
    end
  end

  // counters and syncs share one edge; syncs decode the next count so they line up with pixel_x/pixel_y
  always_ff @(posedge boardCLK or posedge reset) begin
    if (reset) begin
      hCnt     <= 10'd0;
      vCnt     <= 10'd0;
      hsyncReg <= ~SYNC_POL;
      vsyncReg <= ~SYNC_POL;
    end else begin
      hCnt     <= hNext;
      vCnt     <= vNext;
      hsyncReg <= ((hNext >= HS_START) && (hNext <= HS_END)) ? SYNC_POL : ~SYNC_POL;
      vsyncReg <= ((vNext >= VS_START) && (vNext <= VS_END)) ? SYNC_POL : ~SYNC_POL;
    end
  end

  assign vga.pixel_tick  = tick;
  assign vga.hsync       = hsyncReg;
  assign vga.vsync       = vsyncReg;
  assign vga.video_on    = (hCnt < H_VIS) && (vCnt < V_VIS);
  assign vga.pixel_x     = hCnt;
  assign vga.pixel_y     = vCnt;
  assign vga.frame_start = tick & frameEnd;

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb/tb_vga_timing_gen.sv - self-checking bench for vga_timing_gen (full-size and shrunken-timing instances)
module tb_vga_timing_gen;

  typedef struct {
    int         ticks;
    logic [9:0] x;
    logic [9:0] y;
    logic       hs;
    logic       vs;
    logic       von;
  } vec_t;

  logic boardCLK = 1'b0;
  logic resetA   = 1'b1;
  logic resetB   = 1'b1;
  logic vgaClk   = 1'b0;
  logic vgaRun   = 1'b0;
  int   divCnt   = 0;
  int   riseCnt  = 0;
  int   tickA    = 0;
  int   tickB    = 0;
  int   nCompared = 0;
  int   nFail     = 0;

  vec_t sbQ[$];
  int   fsTick[$];
  int   fsX[$];
  int   fsY[$];

  vga_timing_gen_if vgaA();
  vga_timing_gen_if vgaB();

  assign vgaA.vgaCLK = vgaClk;
  assign vgaB.vgaCLK = vgaClk;

  vga_timing_gen dutA (
    .boardCLK (boardCLK),
    .reset    (resetA),
    .vga      (vgaA)
  );

  // small geometry: line 30 ticks (hsync 20..25), frame 15 lines (vsync 10..11)
  vga_timing_gen #(
    .H_ACTIVE (16), .H_FP (4), .H_SYNC (6), .H_BP (4),
    .V_ACTIVE (8),  .V_FP (2), .V_SYNC (2), .V_BP (3),
    .SYNC_POL (1'b0)
  ) dutB (
    .boardCLK (boardCLK),
    .reset    (resetB),
    .vga      (vgaB)
  );

  initial forever #5 boardCLK = ~boardCLK;

  // 25 MHz divider model: toggles every 2 boardCLK cycles while running
  initial forever begin
    @(negedge boardCLK);
    if (vgaRun) begin
      divCnt++;
      if (divCnt == 2) begin
        divCnt = 0;
        vgaClk = ~vgaClk;
        if (vgaClk) riseCnt++;
      end
    end
  end

  // tick counters and frame_start capture, sampled mid-cycle
  initial forever begin
    @(negedge boardCLK);
    if (resetA) tickA = 0;
    else if (vgaA.pixel_tick) tickA++;
    if (resetB) tickB = 0;
    else begin
      if (vgaB.frame_start) begin
        fsTick.push_back(tickB);
        fsX.push_back(int'(vgaB.pixel_x));
        fsY.push_back(int'(vgaB.pixel_y));
      end
      if (vgaB.pixel_tick) tickB++;
    end
  end

  task automatic check(input string name, input int act, input int exp);
    nCompared++;
    if (act != exp) begin
      nFail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic int curTick(input int which);
    return (which == 0) ? tickA : tickB;
  endfunction

  task automatic advance(input int which, input int n);
    int budget;
    budget = (n - curTick(which)) * 4 + 100;
    while (curTick(which) < n && budget > 0) begin
      @(posedge boardCLK); #1;
      budget--;
    end
    if (curTick(which) < n) begin
      nCompared++;
      nFail++;
      $display("FAIL advance_timeout dut%0d: tick %0d, expected %0d", which, curTick(which), n);
    end
  endtask

  initial begin
    vec_t vecs[10];
    vec_t e;
    int   k;
    int   hsLow;
    int   firstHs;
    int   vonFall;
    int   prevVon;
    int   prevX;
    int   prevY;
    int   yChanges;
    int   vsLow;
    int   hsLowB;
    int   firstVs;
    int   start;
    int   savedX;
    int   savedHs;
    int   savedTick;
    int   sawTick;

    vecs[0] = '{4,   10'd4,   10'd0, 1'b1, 1'b1, 1'b1};
    vecs[1] = '{639, 10'd639, 10'd0, 1'b1, 1'b1, 1'b1};
    vecs[2] = '{640, 10'd640, 10'd0, 1'b1, 1'b1, 1'b0};
    vecs[3] = '{655, 10'd655, 10'd0, 1'b1, 1'b1, 1'b0};
    vecs[4] = '{656, 10'd656, 10'd0, 1'b0, 1'b1, 1'b0};
    vecs[5] = '{700, 10'd700, 10'd0, 1'b0, 1'b1, 1'b0};
    vecs[6] = '{751, 10'd751, 10'd0, 1'b0, 1'b1, 1'b0};
    vecs[7] = '{752, 10'd752, 10'd0, 1'b1, 1'b1, 1'b0};
    vecs[8] = '{799, 10'd799, 10'd0, 1'b1, 1'b1, 1'b0};
    vecs[9] = '{800, 10'd0,   10'd1, 1'b1, 1'b1, 1'b1};

    repeat (3) @(posedge boardCLK);
    #1;
    check("reset_x", int'(vgaA.pixel_x), 0);
    check("reset_y", int'(vgaA.pixel_y), 0);
    check("reset_hsync", int'(vgaA.hsync), 1);
    check("reset_vsync", int'(vgaA.vsync), 1);
    check("reset_video_on", int'(vgaA.video_on), 1);
    check("reset_tick", int'(vgaA.pixel_tick), 0);
    check("reset_frame_start", int'(vgaA.frame_start), 0);

    resetA = 1'b0;
    resetB = 1'b0;

`ifdef VGA_EDGE_DETECT_EN
    vgaRun = 1'b1;
    k = 0;
    while (riseCnt == 0 && k < 20) begin
      @(posedge boardCLK); #1;
      k++;
    end
    k = 1;
    while (vgaA.pixel_x == 10'd0 && k < 20) begin
      @(posedge boardCLK); #1;
      k++;
    end
    check("first_tick_after_rise", k, 3);
`else
    k = 0;
    while (!vgaA.pixel_tick && k < 20) begin
      @(posedge boardCLK); #1;
      k++;
    end
    check("first_tick_after_release", k, 3);
    for (int j = 0; j < 3; j++) begin
      k = 0;
      do begin
        @(posedge boardCLK); #1;
        k++;
      end while (!vgaA.pixel_tick && k < 20);
      check("tick_interval", k, 4);
    end
`endif

    for (int i = 0; i < 10; i++) begin
      sbQ.push_back(vecs[i]);
      advance(0, vecs[i].ticks);
      e = sbQ.pop_front();
      check($sformatf("vec%0d_x", i), int'(vgaA.pixel_x), int'(e.x));
      check($sformatf("vec%0d_y", i), int'(vgaA.pixel_y), int'(e.y));
      check($sformatf("vec%0d_hsync", i), int'(vgaA.hsync), int'(e.hs));
      check($sformatf("vec%0d_vsync", i), int'(vgaA.vsync), int'(e.vs));
      check($sformatf("vec%0d_video_on", i), int'(vgaA.video_on), int'(e.von));
    end

    hsLow = 0; firstHs = -1; vonFall = -1; yChanges = 0;
    prevVon = int'(vgaA.video_on);
    prevX = int'(vgaA.pixel_x);
    prevY = int'(vgaA.pixel_y);
    for (int i = 0; i < 800; i++) begin
      advance(0, tickA + 1);
      if (!vgaA.hsync) begin
        hsLow++;
        if (firstHs < 0) firstHs = int'(vgaA.pixel_x);
      end
      if (prevVon == 1 && !vgaA.video_on && vonFall < 0) vonFall = int'(vgaA.pixel_x);
      if (int'(vgaA.pixel_y) != prevY) begin
        yChanges++;
        check("wrap_prev_x", prevX, 799);
        check("wrap_x", int'(vgaA.pixel_x), 0);
      end
      prevVon = int'(vgaA.video_on);
      prevX = int'(vgaA.pixel_x);
      prevY = int'(vgaA.pixel_y);
    end
    check("line_hsync_low_ticks", hsLow, 96);
    check("line_hsync_first_x", firstHs, 656);
    check("line_video_off_x", vonFall, 640);
    check("line_y_changes", yChanges, 1);
    check("line_end_y", int'(vgaA.pixel_y), 2);

    advance(1, 1400);
    for (int f = 0; f < 3; f++) begin
      if (fsTick.size() == 0) begin
        nCompared++;
        nFail++;
        $display("FAIL frame_start_missing: got 0 pulses, expected pulse %0d", f);
      end else begin
        check($sformatf("frame_start%0d_tick", f), fsTick.pop_front(), 449 + 450 * f);
        check($sformatf("frame_start%0d_x", f), fsX.pop_front(), 29);
        check($sformatf("frame_start%0d_y", f), fsY.pop_front(), 14);
      end
    end

    start = (tickB / 450 + 1) * 450;
    advance(1, start);
    check("frame_origin_x", int'(vgaB.pixel_x), 0);
    check("frame_origin_y", int'(vgaB.pixel_y), 0);
    vsLow = 0; hsLowB = 0; firstVs = -1;
    for (int i = 0; i < 450; i++) begin
      advance(1, tickB + 1);
      if (!vgaB.vsync) begin
        vsLow++;
        if (firstVs < 0) firstVs = int'(vgaB.pixel_y);
      end
      if (!vgaB.hsync) hsLowB++;
    end
    check("frame_vsync_low_ticks", vsLow, 60);
    check("frame_vsync_first_y", firstVs, 10);
    check("frame_hsync_low_ticks", hsLowB, 90);

    advance(1, tickB + 9 * 30 + 22);
    check("midframe_x", int'(vgaB.pixel_x), 22);
    check("midframe_y", int'(vgaB.pixel_y), 9);
    check("midframe_hsync", int'(vgaB.hsync), 0);
    check("midframe_video_on", int'(vgaB.video_on), 0);
    resetB = 1'b1;
    #1;
    check("async_reset_x", int'(vgaB.pixel_x), 0);
    check("async_reset_y", int'(vgaB.pixel_y), 0);
    check("async_reset_hsync", int'(vgaB.hsync), 1);
    check("async_reset_video_on", int'(vgaB.video_on), 1);
    repeat (5) @(posedge boardCLK);
    #1;
    check("held_reset_tick", int'(vgaB.pixel_tick), 0);
    check("held_reset_x", int'(vgaB.pixel_x), 0);
    resetB = 1'b0;
    advance(1, 1);
    check("resume_x", int'(vgaB.pixel_x), 1);
    check("resume_y", int'(vgaB.pixel_y), 0);

`ifdef VGA_EDGE_DETECT_EN
    vgaRun = 1'b0;
    repeat (4) @(posedge boardCLK);
    #1;
    savedX = int'(vgaA.pixel_x);
    savedHs = int'(vgaA.hsync);
    savedTick = tickA;
    sawTick = 0;
    repeat (100) begin
      @(posedge boardCLK); #1;
      if (vgaA.pixel_tick) sawTick = 1;
    end
    check("stall_no_tick", sawTick, 0);
    check("stall_x_frozen", int'(vgaA.pixel_x), savedX);
    check("stall_hsync_frozen", int'(vgaA.hsync), savedHs);
    check("stall_tick_count", tickA, savedTick);
    vgaRun = 1'b1;
    advance(0, tickA + 5);
    check("stall_resume_x", int'(vgaA.pixel_x), (savedX + 5) % 800);
`else
    savedX = int'(vgaA.pixel_x);
    savedHs = 0;
    savedTick = tickA;
    sawTick = 0;
    repeat (100) begin
      @(posedge boardCLK); #1;
      if (vgaA.pixel_tick) sawTick++;
    end
    check("tied_vgaclk_tick_count", sawTick, 25);
    check("tied_vgaclk_x", int'(vgaA.pixel_x), (savedX + (tickA - savedTick)) % 800);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nFail);
    $finish;
  end

endmodule
